// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and defaults for the pipeline sequencing controller.
// Imported by the interface, the MUL/DIV counter and the top level.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam int N_DEF      = 32;
  localparam int MD_LAT_DEF = 8;
  localparam int CNT_W_DEF  = 16;
  localparam int REG_ZERO   = 0;

  function automatic int md_cnt_w(input int lat);
    return $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Hazard inputs from ID/EX and pipeline control outputs.
// master drives the hazard inputs, slave is the controller.
interface hazard_stall_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int CNT_W = CNT_W_DEF
);
  localparam int RW = $clog2(N);

  logic [RW-1:0]    rs_id;
  logic [RW-1:0]    rt_id;
  logic [RW-1:0]    write_reg_ex;
  logic             mem_read_ex;
  logic             branch_taken_ex;
  logic             md_start_ex;
  logic             md_use_id;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             md_busy;
  logic             md_done;
  logic             md_err;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output rs_id, rt_id, write_reg_ex,
    output mem_read_ex, branch_taken_ex,
    output md_start_ex, md_use_id,
    input  pc_write, if_id_write,
    input  if_id_flush, id_ex_flush,
    input  md_busy, md_done, md_err,
    input  stall_cycles
  );

  modport slave (
    input  rs_id, rt_id, write_reg_ex,
    input  mem_read_ex, branch_taken_ex,
    input  md_start_ex, md_use_id,
    output pc_write, if_id_write,
    output if_id_flush, id_ex_flush,
    output md_busy, md_done, md_err,
    output stall_cycles
  );

endinterface

// File: rtl/hazard_stall_ctrl_md_latency_counter.sv
// MUL/DIV occupancy tracker: loads MD_LAT on issue, counts down to 1.
// Flags a sticky error when a new issue arrives while still busy.
module md_latency_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_LAT = MD_LAT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  output logic err
);
  localparam int CW = md_cnt_w(MD_LAT);
  localparam logic [CW-1:0] LAT = CW'(MD_LAT);
  localparam logic [CW-1:0] ONE = CW'(1);

  md_state_e     state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (start) begin
            state <= MD_BUSY;
            cnt   <= LAT;
          end
        end
        MD_BUSY: begin
          // the unit in flight is older than any new issue: keep it
          cnt <= cnt - ONE;
          if (start) err <= 1'b1;
          if (cnt == ONE) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  assign busy = (state == MD_BUSY);
  assign done = busy && (cnt == ONE);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing: load-use and MUL/DIV stalls, taken-branch flushes,
// and a saturating count of cycles in which the PC was held.
module hazard_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int MD_LAT = MD_LAT_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_stall_ctrl_if.slave   bus
);
  localparam int RW = $clog2(N);
  localparam logic [RW-1:0] R0 = RW'(REG_ZERO);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             md_busy_q;
  logic             md_done_q;
  logic             md_err_q;
  logic             load_use;
  logic             md_stall;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic [CNT_W-1:0] stall_q;

  md_latency_counter #(
    .MD_LAT (MD_LAT)
  ) u_md (
    .clk   (clk),
    .rst   (rst),
    .start (bus.md_start_ex),
    .busy  (md_busy_q),
    .done  (md_done_q),
    .err   (md_err_q)
  );

  assign load_use = bus.mem_read_ex
                 && (bus.write_reg_ex != R0)
                 && ((bus.write_reg_ex == bus.rs_id)
                  || (bus.write_reg_ex == bus.rt_id));

  // the result is bypassable on the final busy cycle
  assign md_stall = md_busy_q && bus.md_use_id && !md_done_q;

  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (rst) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (bus.branch_taken_ex) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use || md_stall) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (!pc_write && (stall_q != '1)) begin
      stall_q <= stall_q + CNT_ONE;
    end
  end

  assign bus.pc_write     = pc_write;
  assign bus.if_id_write  = if_id_write;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_flush  = id_ex_flush;
  assign bus.md_busy      = md_busy_q && !rst;
  assign bus.md_done      = md_done_q && !rst;
  assign bus.md_err       = md_err_q;
  assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios then random traffic,
// checked against a cycle-indexed reference model.
module tb_hazard_stall_ctrl;
  localparam int N      = 32;
  localparam int MD_LAT = 8;
  localparam int CNT_W  = 4;
  localparam int SAT    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  hazard_stall_ctrl_if #(.N(N), .CNT_W(CNT_W)) bus ();

  hazard_stall_ctrl #(
    .N      (N),
    .MD_LAT (MD_LAT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // model: absolute cycle number and the last cycle of the current busy window
  int cyc      = 0;
  int busy_end = -1;
  bit err_m    = 1'b0;
  int stalls_m = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive(input int rs, input int rt, input int wr,
                       input bit mr, input bit br, input bit st,
                       input bit use_md);
    bus.rs_id           = 5'(rs);
    bus.rt_id           = 5'(rt);
    bus.write_reg_ex    = 5'(wr);
    bus.mem_read_ex     = mr;
    bus.branch_taken_ex = br;
    bus.md_start_ex     = st;
    bus.md_use_id       = use_md;
  endtask

  task automatic idle();
    drive(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // called just after a falling edge with inputs already driven
  task automatic step();
    bit busy, done, lu, ms, pw, flush_a, flush_b;
    int wr;
    #1;
    wr   = int'(bus.write_reg_ex);
    busy = (cyc <= busy_end);
    done = busy && (cyc == busy_end);
    lu   = bus.mem_read_ex && wr != 0 &&
           (wr == int'(bus.rs_id) || wr == int'(bus.rt_id));
    ms   = busy && bus.md_use_id && !done;
    pw   = bus.branch_taken_ex || !(lu || ms);
    flush_a = bus.branch_taken_ex;
    flush_b = bus.branch_taken_ex || lu || ms;
    check("pc_write",     32'(bus.pc_write),     32'(pw));
    check("if_id_write",  32'(bus.if_id_write),  32'(pw));
    check("if_id_flush",  32'(bus.if_id_flush),  32'(flush_a));
    check("id_ex_flush",  32'(bus.id_ex_flush),  32'(flush_b));
    check("md_busy",      32'(bus.md_busy),      32'(busy));
    check("md_done",      32'(bus.md_done),      32'(done));
    check("md_err",       32'(bus.md_err),       32'(err_m));
    check("stall_cycles", 32'(bus.stall_cycles), 32'(stalls_m));
    @(posedge clk);
    if (bus.md_start_ex) begin
      if (busy) err_m = 1'b1;
      else busy_end = cyc + MD_LAT;
    end
    if (!pw && stalls_m < SAT) stalls_m++;
    cyc++;
    @(negedge clk);
  endtask

  // async reset asserted mid low phase, held across one rising edge
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    check("rst_pc_write",    32'(bus.pc_write),    32'd0);
    check("rst_if_id_write", 32'(bus.if_id_write), 32'd0);
    check("rst_if_id_flush", 32'(bus.if_id_flush), 32'd1);
    check("rst_id_ex_flush", 32'(bus.id_ex_flush), 32'd1);
    check("rst_md_busy",     32'(bus.md_busy),     32'd0);
    check("rst_md_done",     32'(bus.md_done),     32'd0);
    @(posedge clk);
    #1;
    check("rst_stall_cycles", 32'(bus.stall_cycles), 32'd0);
    check("rst_md_err",       32'(bus.md_err),       32'd0);
    @(negedge clk);
    rst      = 1'b0;
    busy_end = -1;
    err_m    = 1'b0;
    stalls_m = 0;
    cyc      = cyc + 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    @(negedge clk);
    do_reset();
    idle();
    step();

    // load-use on rs, then register 0 never matches
    drive(5, 9, 5, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    idle();
    step();
    check("lu_count", 32'(bus.stall_cycles), 32'd1);
    drive(0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(7, 3, 3, 1'b1, 1'b0, 1'b0, 1'b0);
    step();

    // branch squashes a simultaneous load-use
    drive(5, 5, 5, 1'b1, 1'b1, 1'b0, 1'b0);
    step();

    // MUL/DIV with consumer held in ID, second issue at cycle 3
    do_reset();
    drive(0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    for (int i = 1; i <= 10; i++) begin
      drive(0, 0, 0, 1'b0, 1'b0, i == 3, 1'b1);
      step();
    end
    check("md_stall_total", 32'(bus.stall_cycles), 32'd7);
    check("md_err_sticky",  32'(bus.md_err),       32'd1);

    // branch during busy does not abort the unit
    drive(0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    drive(0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    for (int i = 0; i < 3; i++) begin
      idle();
      step();
    end

    // reset in the middle of a MUL/DIV
    drive(0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
    end
    do_reset();
    drive(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();

    // saturation of the stall counter
    for (int i = 0; i < 20; i++) begin
      drive(4, 1, 4, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
    end
    idle();
    step();
    check("sat_count", 32'(bus.stall_cycles), 32'(SAT));

    // random traffic with small register range so hazards are frequent
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drive(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)),
            $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 0);
      if ($urandom_range(0, 399) == 0) do_reset();
      else step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
